aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_key_expander.sv | 141 ++++++++++++++
 tb/tb_aes_key_expander.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// AES key schedule generator: produces one 32-bit schedule word per cycle and
// hands round keys out over a valid/ready port, oldest first.
module aes_key_expander #(
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk,
    output logic [3:0]       rk_idx,
    output logic             done
);
    localparam int NK = KEY_W / 32;
    localparam int NR = NK + 6;
    localparam logic [5:0] NK6   = 6'(NK);
    localparam logic [5:0] LAST6 = 6'(4 * NR + 3);
    localparam logic [2:0] NKM1  = 3'(NK - 1);
    localparam logic [3:0] NR4   = 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

    state_t      state;
    logic [31:0] win [NK];
    logic [5:0]  widx;
    logic [2:0]  phase;
    logic [7:0]  rcon;
    logic [31:0] asm_w [3];
    logic [1:0]  asm_cnt;
    logic [31:0] temp, sub_in, sub_out, wnew;
    logic        step;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // The window rotates while the key words are emitted, so after NK steps it
    // holds w[0..NK-1] in order and win[0] is always w[i-NK].
    always_comb begin
        temp    = win[NK-1];
        sub_in  = (phase == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
        sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
        if (widx < NK6)
            wnew = win[0];
        else if (phase == 3'd0)
            wnew = win[0] ^ sub_out ^ {rcon, 24'h0};
        else if (NK == 8 && phase == 3'd4)
            wnew = win[0] ^ sub_out;
        else
            wnew = win[0] ^ temp;
    end

    assign step = (state == GEN) && !(asm_cnt == 2'd3 && rk_valid && !rk_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk       <= '0;
            rk_idx   <= '0;
            done     <= 1'b0;
            rcon     <= '0;
            widx     <= '0;
            phase    <= '0;
            asm_cnt  <= '0;
            for (int unsigned k = 0; k < NK; k++) win[k] <= '0;
            for (int unsigned k = 0; k < 3; k++) asm_w[k] <= '0;
        end else begin
            done <= 1'b0;
            if (rk_valid && rk_ready)
                rk_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= GEN;
                        busy    <= 1'b1;
                        rcon    <= 8'h01;
                        widx    <= '0;
                        phase   <= '0;
                        asm_cnt <= '0;
                        for (int unsigned k = 0; k < NK; k++)
                            win[k] <= key[KEY_W-1-32*k -: 32];
                    end
                end
                GEN: begin
                    if (step) begin
                        for (int unsigned k = 0; k + 1 < NK; k++) win[k] <= win[k+1];
                        win[NK-1] <= wnew;
                        widx  <= widx + 6'd1;
                        phase <= (phase == NKM1) ? 3'd0 : phase + 3'd1;
                        if (widx >= NK6 && phase == 3'd0)
                            rcon <= xtime(rcon);
                        // The fourth word bypasses the buffer straight into rk.
                        if (asm_cnt == 2'd3) begin
                            rk       <= {asm_w[0], asm_w[1], asm_w[2], wnew};
                            rk_valid <= 1'b1;
                            rk_idx   <= widx[5:2];
                            asm_cnt  <= '0;
                        end else begin
                            asm_w[asm_cnt] <= wnew;
                            asm_cnt        <= asm_cnt + 2'd1;
                        end
                        if (widx == LAST6)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rk_valid && rk_ready && rk_idx == NR4) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: one instance per key size, round keys compared
// against a schedule model built from a GF(2^8)-derived S-box.
module tb_aes_key_expander;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         start [3];
    logic [255:0] key   [3];
    logic         ready [3];
    logic         busy  [3];
    logic         valid [3];
    logic         done  [3];
    logic [127:0] rk    [3];
    logic [3:0]   idx   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int KW = 128 + 64 * g;
        aes_key_expander #(.KEY_W(KW)) dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .key(key[g][255 -: KW]),
            .busy(busy[g]), .rk_valid(valid[g]), .rk_ready(ready[g]),
            .rk(rk[g]), .rk_idx(idx[g]), .done(done[g])
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb  [256];
    logic [31:0]  mw  [60];
    logic [127:0] mrk [15];
    logic [127:0] got [15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sb[a] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic model(input logic [255:0] k, input int nk);
        int nr;
        logic [7:0] rc;
        logic [31:0] t;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                mw[i] = k[255 - 32 * i -: 32];
            end else begin
                t = mw[i-1];
                if (i % nk == 0) begin
                    t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subword(t);
                end
                mw[i] = mw[i-nk] ^ t;
            end
        end
        for (int j = 0; j <= nr; j++) mrk[j] = {mw[4*j], mw[4*j+1], mw[4*j+2], mw[4*j+3]};
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: ready held high; 1: random ready and start pulses while busy;
    // 2: ready low for 10 cycles once round key 0 is offered.
    task automatic run(input int d, input logic [255:0] k, input int mode, input int abort_at);
        int nk, nr, n, cyc, first;
        bit fin, pv;
        logic [127:0] prk;
        logic [3:0] pidx;
        nk = 4 + 2 * d; nr = nk + 6;
        n = 0; cyc = 0; first = -1; fin = 0; pv = 0;
        prk = '0; pidx = '0;
        model(k, nk);
        @(negedge clk);
        ready[d] = 1'b0; key[d] = k; start[d] = 1'b1;
        @(negedge clk);
        while (!fin && cyc < 2000) begin
            cyc++;
            if (cyc == 1) check("busy_after_start", 128'(busy[d]), 128'd1);
            key[d] = rand256();
            start[d] = (mode == 1 && n < nr) ? 1'($urandom) : 1'b0;
            if (valid[d] && first < 0) first = cyc;
            case (mode)
                0: ready[d] = 1'b1;
                1: ready[d] = 1'($urandom);
                default: ready[d] = (first >= 0 && cyc - first >= 10);
            endcase
            if (pv) begin
                check("hold_valid", 128'(valid[d]), 128'd1);
                check("hold_rk", rk[d], prk);
                check("hold_idx", 128'(idx[d]), 128'(pidx));
            end
            if (abort_at >= 0 && valid[d] && int'(idx[d]) == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_busy", 128'(busy[d]), 128'd0);
                check("rst_valid", 128'(valid[d]), 128'd0);
                check("rst_rk", rk[d], 128'd0);
                check("rst_idx", 128'(idx[d]), 128'd0);
                check("rst_done", 128'(done[d]), 128'd0);
                start[d] = 1'b0; ready[d] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check("no_early_done", 128'(done[d]), 128'd0);
            if (valid[d] && ready[d]) begin
                check("rk_idx_order", 128'(idx[d]), 128'(n));
                check("rk_value", rk[d], mrk[n]);
                if (mode == 0) check("rk_cadence", 128'(cyc), 128'(first + 4 * n));
                got[n] = rk[d];
                n++;
                if (n == nr + 1) begin
                    @(negedge clk);
                    start[d] = 1'b0;
                    check("done_pulse", 128'(done[d]), 128'd1);
                    check("busy_fall", 128'(busy[d]), 128'd0);
                    check("valid_after_last", 128'(valid[d]), 128'd0);
                    @(negedge clk);
                    check("done_one_cycle", 128'(done[d]), 128'd0);
                    fin = 1;
                end
            end
            pv = valid[d] && !ready[d];
            prk = rk[d];
            pidx = idx[d];
            if (!fin) @(negedge clk);
        end
        start[d] = 1'b0;
        ready[d] = 1'b0;
        if (!fin) check("timeout", 128'd0, 128'd1);
        if (mode == 0) check("first_valid_latency", 128'(first), 128'd5);
    endtask

    typedef struct {
        int           d;
        logic [255:0] k;
        int           mode;
        int           j;
        logic [127:0] exp;
    } vec_t;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        #1000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{0, K128, 0, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[1] = '{0, K128, 0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[2] = '{1, K192, 0, 12, 128'he98ba06f448c773c8ecc720401002202};
        tbl[3] = '{2, K256, 0, 14, 128'hfe4890d1e6188d0b046df344706c631e};
        tbl[4] = '{0, K128, 2, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[5] = '{0, K128, 1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0; ready[g] = 1'b0; key[g] = '0;
        end
        build_sbox();
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("reset_busy", 128'(busy[g]), 128'd0);
            check("reset_valid", 128'(valid[g]), 128'd0);
            check("reset_rk", rk[g], 128'd0);
            check("reset_idx", 128'(idx[g]), 128'd0);
            check("reset_done", 128'(done[g]), 128'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 15; j++) got[j] = '0;
            run(tbl[t].d, tbl[t].k, tbl[t].mode, -1);
            check("known_vector", got[tbl[t].j], tbl[t].exp);
        end

        run(0, K128, 0, 5);
        for (int j = 0; j < 15; j++) got[j] = '0;
        run(0, K128, 0, -1);
        check("after_reset_rk0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("after_reset_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int r = 0; r < 2; r++)
            for (int g = 0; g < 3; g++)
                run(g, rand256(), (r == 0) ? 1 : 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
